// File: rtl/spm_bus_if.sv
// Per-stage memory access initiator: routes pipeline requests to the SPM port
// (one-cycle read turnaround) or to the shared system bus (req/grant/ready).
module spm_bus_if #(
  parameter int          SPM_ADDR_W = 12,
  parameter logic [2:0]  SPM_SEL    = 3'b011
) (
  input  logic                  clk,
  input  logic                  reset_,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [29:0]           cpu_addr,
  input  logic                  cpu_as_,
  input  logic                  cpu_rw,
  input  logic [31:0]           cpu_wr_data,
  output logic [31:0]           rd_data,
  output logic                  busy,
  output logic [SPM_ADDR_W-1:0] spm_addr,
  output logic                  spm_as_,
  output logic                  spm_rw,
  output logic [31:0]           spm_wr_data,
  input  logic [31:0]           spm_rd_data,
  output logic                  bus_req_,
  input  logic                  bus_grnt_,
  output logic [29:0]           bus_addr,
  output logic                  bus_as_,
  output logic                  bus_rw,
  output logic [31:0]           bus_wr_data,
  input  logic [31:0]           bus_rd_data,
  input  logic                  bus_rdy_,
  output logic [2:0]            o_dbg_state
);

  // Handshake: the stage holds cpu_* steady while busy is 1; a read result is
  // valid on rd_data in the cycle busy is 0 that ends the access.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SPM_RD    = 3'd1,
    BUS_REQ   = 3'd2,
    BUS_ACC   = 3'd3,
    BUS_STALL = 3'd4
  } state_t;

  state_t      r_state;
  logic [31:0] r_rd_buf;
  logic        r_bus_req_;
  logic        r_bus_as_;
  logic        r_bus_rw;
  logic [29:0] r_bus_addr;
  logic [31:0] r_bus_wr_data;

  logic w_req;
  logic w_hit;
  logic w_spm_sel;

  assign w_req     = !cpu_as_ && !flush && (r_state == IDLE);
  assign w_hit     = (cpu_addr[29:27] == SPM_SEL);
  assign w_spm_sel = w_req && w_hit && reset_;

  assign spm_addr    = cpu_addr[SPM_ADDR_W-1:0];
  assign spm_wr_data = cpu_wr_data;
  assign spm_as_     = !w_spm_sel;
  assign spm_rw      = w_spm_sel ? cpu_rw : 1'b1;

  assign bus_req_    = r_bus_req_;
  assign bus_as_     = r_bus_as_;
  assign bus_rw      = r_bus_rw;
  assign bus_addr    = r_bus_addr;
  assign bus_wr_data = r_bus_wr_data;
  assign o_dbg_state = r_state;

  always_comb begin
    busy    = 1'b0;
    rd_data = r_rd_buf;
    case (r_state)
      IDLE:      busy = w_req && (!w_hit || cpu_rw);
      SPM_RD:    rd_data = spm_rd_data;
      BUS_REQ:   busy = 1'b1;
      BUS_ACC: begin
        busy = bus_rdy_;
        if (!bus_rdy_) rd_data = bus_rd_data;
      end
      BUS_STALL: rd_data = r_rd_buf;
      default:   busy = 1'b0;
    endcase
    if (!reset_) begin
      busy    = 1'b0;
      rd_data = 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      r_state       <= IDLE;
      r_rd_buf      <= 32'h0;
      r_bus_req_    <= 1'b1;
      r_bus_as_     <= 1'b1;
      r_bus_rw      <= 1'b1;
      r_bus_addr    <= 30'h0;
      r_bus_wr_data <= 32'h0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            if (w_hit) begin
              if (cpu_rw) r_state <= SPM_RD;
            end else begin
              r_bus_req_    <= 1'b0;
              r_bus_addr    <= cpu_addr;
              r_bus_rw      <= cpu_rw;
              r_bus_wr_data <= cpu_wr_data;
              r_state       <= BUS_REQ;
            end
          end
        end
        SPM_RD: begin
          r_rd_buf <= spm_rd_data;
          r_state  <= stall ? BUS_STALL : IDLE;
        end
        BUS_REQ: begin
          // Ready in this state is ignored; only grant moves us on.
          if (!bus_grnt_) begin
            r_bus_as_ <= 1'b0;
            r_state   <= BUS_ACC;
          end
        end
        BUS_ACC: begin
          r_bus_as_ <= 1'b1;
          if (!bus_rdy_) begin
            if (r_bus_rw) r_rd_buf <= bus_rd_data;
            r_bus_req_ <= 1'b1;
            r_state    <= stall ? BUS_STALL : IDLE;
          end
        end
        BUS_STALL: begin
          if (!stall) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
